// File: rtl/fifo_wptr_full.sv
// Write-domain half of an async FIFO: binary/Gray write pointer, read-pointer
// synchroniser, and the full / almost_full / level / overflow flags.
module fifo_wptr_full #(
  parameter int PTR       = 8,
  parameter int AF_THRESH = (1 << PTR) - 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [PTR:0]   rd_gray_ptr,
  output logic [PTR-1:0] wr_addr,
  output logic [PTR:0]   wr_bin_ptr,
  output logic [PTR:0]   wr_gray_ptr,
  output logic           full,
  output logic           almost_full,
  output logic [PTR:0]   wr_level,
  output logic           overflow
);

  localparam logic [PTR:0] AF_LEVEL = (PTR + 1)'(AF_THRESH);

  logic [PTR:0] rq1, rq2;
  logic [PTR:0] rbin_sync;
  logic [PTR:0] wbin_next, wgray_next, level_next;
  logic         push;

  // Each binary bit is the XOR of the Gray bits at and above it.
  always_comb begin
    for (int i = 0; i <= PTR; i++) begin
      rbin_sync[i] = ^(rq2 >> i);
    end
  end

  // NOTE: every always_comb output is assigned first thing, so no path leaves
  // a value held over from a previous evaluation (which would infer a latch).
  always_comb begin
    push       = wr_en & ~full;
    wbin_next  = wr_bin_ptr + (PTR + 1)'(push);
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    level_next = wbin_next - rbin_sync;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge; blocking here would collapse the rq1->rq2 chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bin_ptr  <= '0;
      wr_gray_ptr <= '0;
      rq1         <= '0;
      rq2         <= '0;
      wr_level    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rq1         <= rd_gray_ptr;
      rq2         <= rq1;
      wr_bin_ptr  <= wbin_next;
      wr_gray_ptr <= wgray_next;
      wr_level    <= level_next;
      // Full when the write pointer has lapped the read pointer exactly once:
      // top two Gray bits inverted, remainder equal.
      full        <= (wgray_next == {~rq2[PTR:PTR-1], rq2[PTR-2:0]});
      almost_full <= (level_next >= AF_LEVEL);
      overflow    <= wr_en & full;
    end
  end

  assign wr_addr = wr_bin_ptr[PTR-1:0];

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full at PTR=2, AF_THRESH=3; all expected values
// are hand-computed from the pointer arithmetic.
module tb_fifo_wptr_full;

  localparam int PTR = 2;
  localparam int AF  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr_en = 1'b0;
  logic [PTR:0]   rd_gray_ptr = '0;
  logic [PTR-1:0] wr_addr;
  logic [PTR:0]   wr_bin_ptr, wr_gray_ptr, wr_level;
  logic           full, almost_full, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wptr_full #(.PTR(PTR), .AF_THRESH(AF)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_gray_ptr (rd_gray_ptr),
    .wr_addr     (wr_addr),
    .wr_bin_ptr  (wr_bin_ptr),
    .wr_gray_ptr (wr_gray_ptr),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int wbin, input int gray,
                              input int lvl, input bit f, input bit af, input bit ov);
    check({tag, ".bin"},   32'(wr_bin_ptr),  32'(wbin));
    check({tag, ".addr"},  32'(wr_addr),     32'(wbin % 4));
    check({tag, ".gray"},  32'(wr_gray_ptr), 32'(gray));
    check({tag, ".level"}, 32'(wr_level),    32'(lvl));
    check({tag, ".full"},  32'(full),        32'(f));
    check({tag, ".af"},    32'(almost_full), 32'(af));
    check({tag, ".ovf"},   32'(overflow),    32'(ov));
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         en;
    logic [2:0] rd;
    int         wbin;
    int         gray;
    int         lvl;
    bit         f;
    bit         ov;
  } vec_t;

  vec_t wrap_v [10];

  int wr_gray_tbl [4];

  initial begin
    wr_gray_tbl = '{1, 3, 2, 6};
    // Reader walks Gray 011..000 while the writer pushes 8 words across the wrap.
    wrap_v = '{
      '{1'b1, 3'b011, 5, 7, 4, 1'b1, 1'b0},
      '{1'b1, 3'b010, 5, 7, 4, 1'b1, 1'b1},
      '{1'b1, 3'b110, 5, 7, 3, 1'b0, 1'b1},
      '{1'b1, 3'b111, 6, 5, 3, 1'b0, 1'b0},
      '{1'b1, 3'b101, 7, 4, 3, 1'b0, 1'b0},
      '{1'b1, 3'b100, 0, 0, 3, 1'b0, 1'b0},
      '{1'b1, 3'b000, 1, 1, 3, 1'b0, 1'b0},
      '{1'b1, 3'b000, 2, 3, 3, 1'b0, 1'b0},
      '{1'b1, 3'b000, 3, 2, 3, 1'b0, 1'b0},
      '{1'b1, 3'b000, 4, 6, 4, 1'b1, 1'b0}
    };

    // Reset with garbage on the read pointer.
    rd_gray_ptr = 3'b101;
    #1 rst = 1'b1;
    #1 expect_state("rst_async", 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    expect_state("rst_held", 0, 0, 0, 0, 0, 0);
    rd_gray_ptr = 3'b000;
    rst = 1'b0;
    tick();
    expect_state("rst_after", 0, 0, 0, 0, 0, 0);

    // Fill from empty: level climbs to 4, almost_full at 3, full on the 4th write.
    wr_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_state($sformatf("fill%0d", i), i, wr_gray_tbl[i-1], i,
                   (i == 4), (i >= AF), 1'b0);
    end

    // Writes while full are dropped and flagged.
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_state($sformatf("ovf%0d", i), 4, 6, 4, 1'b1, 1'b1, 1'b1);
    end

    // One read: full releases on the 3rd edge.
    wr_en = 1'b0;
    rd_gray_ptr = 3'b001;
    tick(); expect_state("rel1", 4, 6, 4, 1'b1, 1'b1, 1'b0);
    tick(); expect_state("rel2", 4, 6, 4, 1'b1, 1'b1, 1'b0);
    tick(); expect_state("rel3", 4, 6, 3, 1'b0, 1'b1, 1'b0);

    // Wrap of both pointers with the reader advancing.
    for (int i = 0; i < 10; i++) begin
      wr_en = wrap_v[i].en;
      rd_gray_ptr = wrap_v[i].rd;
      tick();
      expect_state($sformatf("wrap%0d", i), wrap_v[i].wbin, wrap_v[i].gray,
                   wrap_v[i].lvl, wrap_v[i].f, 1'b1, wrap_v[i].ov);
      check($sformatf("wrap%0d.lvl_le4", i), 32'(wr_level <= 3'd4), 32'd1);
    end

    // Free one slot again.
    wr_en = 1'b0;
    rd_gray_ptr = 3'b001;
    tick(); expect_state("rel_b1", 4, 6, 4, 1'b1, 1'b1, 1'b0);
    tick(); expect_state("rel_b2", 4, 6, 4, 1'b1, 1'b1, 1'b0);
    tick(); expect_state("rel_b3", 4, 6, 3, 1'b0, 1'b1, 1'b0);

    // Last write on the same edge the reader advances: full on the stale rq2.
    wr_en = 1'b1;
    rd_gray_ptr = 3'b011;
    tick(); expect_state("last_a", 5, 7, 4, 1'b1, 1'b1, 1'b0);
    tick(); expect_state("last_b", 5, 7, 4, 1'b1, 1'b1, 1'b1);
    tick(); expect_state("last_c", 5, 7, 3, 1'b0, 1'b1, 1'b1);
    wr_en = 1'b0;
    tick(); expect_state("last_d", 5, 7, 3, 1'b0, 1'b1, 1'b0);

    // Reset mid-operation, between edges.
    #2 rst = 1'b1;
    #1 expect_state("rst_mid", 0, 0, 0, 0, 0, 0);
    tick();
    expect_state("rst_mid_held", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
